ex_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the EX stage. It replaces the single-cycle combinational product that the EX stage currently uses.
- Accepts one operation per start handshake and iterates over WIDTH cycles.
- Returns the low or high product, quotient or remainder, with a one-cycle done pulse.
- EX holds its over signal low until done_o is seen.
- EX uses flush_i to abort work belonging to a cancelled instruction.

---
 rtl/ex_muldiv_unit_pkg.sv | 24 ++
 rtl/ex_muldiv_unit_fix.sv | 37 +++
 rtl/ex_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit shared definitions: op and state encodings.
package ex_muldiv_unit_pkg;

  localparam int MdOpW = 3;

  typedef enum logic [MdOpW-1:0] {
    MD_MUL   = 3'd0,
    MD_MULH  = 3'd1,
    MD_MULHU = 3'd2,
    MD_RSVD  = 3'd3,
    MD_DIV   = 3'd4,
    MD_MOD   = 3'd5,
    MD_DIVU  = 3'd6,
    MD_MODU  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_fix.sv
// ex_muldiv_fix: sign fix-up and special-case selection on the raw accumulator.
module ex_muldiv_fix
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e             op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic               neg_res,
  input  logic               neg_rem,
  input  logic               div_zero,
  input  logic               div_ovf,
  input  logic [WIDTH-1:0]   dividend,
  output logic [WIDTH-1:0]   result
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    prod   = neg_res ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    result = prod[WIDTH-1:0];
    case (op)
      MD_MUL, MD_RSVD:   result = prod[WIDTH-1:0];
      MD_MULH, MD_MULHU: result = prod[2*WIDTH-1:WIDTH];
      MD_DIV:  result = div_zero ? '1 : (div_ovf ? dividend : (neg_res ? -quo : quo));
      MD_MOD:  result = div_zero ? dividend : (div_ovf ? '0 : (neg_rem ? -rem : rem));
      MD_DIVU: result = div_zero ? '1 : quo;
      MD_MODU: result = div_zero ? dividend : rem;
      default: result = prod[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide for EX. Optional MULDIV_FAST_MUL_EN: single-pass multiply.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [MdOpW-1:0] op_i,
  input  logic [WIDTH-1:0] opd1_i,
  input  logic [WIDTH-1:0] opd2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_in;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   dividend_q;
  logic               neg_res_q, neg_rem_q, div_zero_q, div_ovf_q;

  logic               accept, is_div, is_signed, sgn1, sgn2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   trial;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   fix_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0] fast_a, fast_b;
  logic [2*WIDTH-1:0]    fast_prod;

  always_comb begin
    fast_a    = {(op_in == MD_MULH) & opd1_i[WIDTH-1], opd1_i};
    fast_b    = {(op_in == MD_MULH) & opd2_i[WIDTH-1], opd2_i};
    fast_prod = (2*WIDTH)'(fast_a) * (2*WIDTH)'(fast_b);
  end
`endif

  assign op_in  = md_op_e'(op_i);
  assign accept = (state_q == MD_IDLE) & start_i & ~flush_i;
  assign busy_o = (state_q != MD_IDLE);
  assign done_o = (state_q == MD_DONE) & ~flush_i;

  always_comb begin
    is_div    = op_i[2];
    is_signed = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_MOD);
    sgn1      = is_signed & opd1_i[WIDTH-1];
    sgn2      = is_signed & opd2_i[WIDTH-1];
    mag1      = sgn1 ? -opd1_i : opd1_i;
    mag2      = sgn2 ? -opd2_i : opd2_i;
  end

  // Multiply and divide share the accumulator: {hi, lo} = {partial/remainder, multiplier/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial    = rem_sh[WIDTH-1:0] - opb_q;
    if (rem_sh >= {1'b0, opb_q}) begin
      div_next = {trial, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
          state_d = is_div ? MD_CALC : MD_FIX;
`else
          state_d = MD_CALC;
`endif
        end
      end
      MD_CALC: if (cnt_q == CNT_W'(1)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= MD_IDLE;
      op_q       <= MD_MUL;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      dividend_q <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_o   <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i && (state_q != MD_IDLE)) begin
        cnt_q <= '0;
      end else begin
        case (state_q)
          MD_IDLE: begin
            if (accept) begin
              op_q       <= op_in;
              dividend_q <= opd1_i;
              cnt_q      <= CNT_W'(WIDTH);
              neg_res_q  <= sgn1 ^ sgn2;
              neg_rem_q  <= sgn1;
              div_zero_q <= is_div & ~|opd2_i;
              div_ovf_q  <= is_div & is_signed & (&opd2_i) &
                            (opd1_i == {1'b1, {(WIDTH-1){1'b0}}});
              if (is_div) begin
                acc_q <= {{WIDTH{1'b0}}, mag1};
                opb_q <= mag2;
              end else begin
                acc_q <= {{WIDTH{1'b0}}, mag2};
                opb_q <= mag1;
              end
`ifdef MULDIV_FAST_MUL_EN
              // Fast product is already signed-correct; skip the magnitude sign fix.
              if (!is_div) begin
                acc_q     <= fast_prod;
                neg_res_q <= 1'b0;
                cnt_q     <= '0;
              end
`endif
            end
          end
          MD_CALC: begin
            cnt_q <= cnt_q - CNT_W'(1);
            acc_q <= op_q[2] ? div_next : mul_next;
          end
          MD_FIX:  result_o <= fix_res;
          default: ;
        endcase
      end
    end
  end

  ex_muldiv_fix #(.WIDTH(WIDTH)) u_fix (
    .op       (op_q),
    .acc      (acc_q),
    .neg_res  (neg_res_q),
    .neg_rem  (neg_rem_q),
    .div_zero (div_zero_q),
    .div_ovf  (div_ovf_q),
    .dividend (dividend_q),
    .result   (fix_res)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit (WIDTH=32); honours MULDIV_FAST_MUL_EN for multiply latency.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] opd1 = '0;
  logic [W-1:0] opd2 = '0;
  logic         flush = 1'b0;
  logic         busy, done;
  logic [W-1:0] result;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .op_i     (op),
    .opd1_i   (opd1),
    .opd2_i   (opd2),
    .flush_i  (flush),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] exp_res, input string tag,
                        input bit hold);
    int lat;
    bit busy_ok;
    start = 1'b1; op = o; opd1 = a; opd2 = b;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    opd1 = $urandom(); opd2 = $urandom();
    lat = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    chk({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  logic [W-1:0] r0;
  int           c0;

  initial begin
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MD_MUL,   32'h0000_1234, 32'h0000_5678, MUL_LAT, 32'h0626_0060, "mul", 1'b0);
    run_op(MD_MULH,  32'hFFFF_FFFF, 32'h0000_0002, MUL_LAT, 32'hFFFF_FFFF, "mulh", 1'b0);
    run_op(MD_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, MUL_LAT, 32'h0000_0001, "mulhu", 1'b0);
    run_op(MD_MUL,   32'd3,         32'd4,         MUL_LAT, 32'd12,        "mul_3x4", 1'b0);
    run_op(MD_RSVD,  32'd7,         32'd6,         MUL_LAT, 32'd42,        "rsvd_mul", 1'b0);
    run_op(MD_MUL,   32'hFFFF_FFFE, 32'd3,         MUL_LAT, 32'hFFFF_FFFA, "mul_neg_low", 1'b0);
    run_op(MD_MULH,  32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, "mulh_minmin", 1'b0);

    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         DIV_LAT, 32'hFFFF_FFFD, "div_m7_2", 1'b0);
    run_op(MD_MOD,   32'hFFFF_FFF9, 32'd2,         DIV_LAT, 32'hFFFF_FFFF, "mod_m7_2", 1'b0);
    run_op(MD_DIVU,  32'd100,       32'd7,         DIV_LAT, 32'd14,        "divu_100_7", 1'b0);
    run_op(MD_MODU,  32'd100,       32'd7,         DIV_LAT, 32'd2,         "modu_100_7", 1'b0);
    run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, DIV_LAT, 32'hFFFF_FFFD, "div_7_m2", 1'b0);

    run_op(MD_DIV,   32'd5,         32'd0,         DIV_LAT, 32'hFFFF_FFFF, "div_by0", 1'b0);
    run_op(MD_MOD,   32'd5,         32'd0,         DIV_LAT, 32'd5,         "mod_by0", 1'b0);
    run_op(MD_MODU,  32'hFFFF_FFF0, 32'd0,         DIV_LAT, 32'hFFFF_FFF0, "modu_by0", 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h8000_0000, "div_ovf", 1'b0);
    run_op(MD_MOD,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0,         "mod_ovf", 1'b0);

    // start_i held high across the whole operation must not restart it
    run_op(MD_DIVU,  32'd100,       32'd7,         DIV_LAT, 32'd14,        "divu_start_held", 1'b1);

    // start together with flush in IDLE is rejected
    start = 1'b1; flush = 1'b1; op = MD_DIVU; opd1 = 32'd9; opd2 = 32'd3;
    @(negedge clk);
    chk("start_with_flush_rejected", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;

    // flush mid-divide at T+10, restart at T+11
    r0 = result; c0 = done_cnt;
    start = 1'b1; op = MD_DIVU; opd1 = 32'd1000; opd2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'd0);
    chk("flush_result_kept", 64'(result), 64'(r0));
    chk("flush_no_done", 64'(done_cnt), 64'(c0));
    run_op(MD_MODU, 32'd1000, 32'd3, DIV_LAT, 32'd1, "post_flush", 1'b0);

    // asynchronous reset mid-CALC
    c0 = done_cnt;
    start = 1'b1; op = MD_DIVU; opd1 = 32'd50; opd2 = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_result", 64'(result), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("async_rst_no_done", 64'(done_cnt), 64'(c0));
    run_op(MD_MUL, 32'd3, 32'd4, MUL_LAT, 32'd12, "after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
